// File: rtl/uart_transmitter_fifo.sv
// UART transmitter with a small TX FIFO; 5-8 data bits, runtime parity/stop/divisor.
// A push into an idle, empty block starts the frame one clock later; data_in_ready drops while the FIFO is full.
module uart_transmitter_fifo #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic [15:0]                   baud_div,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DEF_DIV = CLOCK_FREQ / BAUD_RATE;
    localparam logic [15:0] DEF_DIV16 = DEF_DIV[15:0];
    localparam int LAST_BIT_I = DATA_BITS - 1;
    localparam logic [2:0] LAST_BIT = LAST_BIT_I[2:0];
    localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 push, pop;

    logic [7:0]  frame_dat;
    logic        frame_par_en, frame_par, frame_two;
    logic [15:0] frame_div;
    logic [15:0] cnt, cnt_n, sel_div, eff_div;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        stop_idx, stop_idx_n, line_n, bit_end;

    assign data_in_ready = (fifo_count != FULL);
    assign push    = data_in_valid & data_in_ready;
    assign busy    = (state != IDLE) | (fifo_count != '0);
    assign sel_div = (baud_div == 16'd0) ? DEF_DIV16 : baud_div;
    assign eff_div = (sel_div < 16'd2) ? 16'd2 : sel_div;
    assign bit_end = (cnt == frame_div - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    // line_n is the value the line takes after this edge, so serial_out stays a plain flop
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        line_n     = 1'b1;
        pop        = 1'b0;
        if (state != IDLE)
            cnt_n = bit_end ? 16'd0 : cnt + 16'd1;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                    cnt_n   = 16'd0;
                    line_n  = 1'b0;
                end
            end
            START: begin
                line_n = 1'b0;
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                    line_n    = frame_dat[0];
                end
            end
            DATA: begin
                line_n = frame_dat[bit_idx];
                if (bit_end) begin
                    if (bit_idx == LAST_BIT) begin
                        stop_idx_n = 1'b0;
                        state_n    = frame_par_en ? PARITY : STOP;
                        line_n     = frame_par_en ? frame_par : 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        line_n    = frame_dat[bit_idx_n];
                    end
                end
            end
            PARITY: begin
                line_n = frame_par;
                if (bit_end) begin
                    state_n    = STOP;
                    stop_idx_n = 1'b0;
                    line_n     = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (frame_two && !stop_idx) begin
                        stop_idx_n = 1'b1;
                    end else if (fifo_count != '0) begin
                        pop     = 1'b1;
                        state_n = START;
                        line_n  = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 16'd0;
            bit_idx      <= 3'd0;
            stop_idx     <= 1'b0;
            serial_out   <= 1'b1;
            frame_dat    <= 8'd0;
            frame_div    <= 16'd2;
            frame_two    <= 1'b0;
            frame_par_en <= 1'b0;
            frame_par    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            stop_idx   <= stop_idx_n;
            serial_out <= line_n;
            // Config is sampled only here, so mid-frame changes wait for the next frame
            if (pop) begin
                frame_dat    <= 8'(mem[rd_ptr]);
                frame_div    <= eff_div;
                frame_two    <= two_stop;
                frame_par_en <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                frame_par    <= (^mem[rd_ptr]) ^ (parity_mode == 2'b10);
            end
        end
    end
endmodule

// File: tb/tb_uart_transmitter_fifo.sv
// Bench for uart_transmitter_fifo: per-cycle line waveform compared against a frame-level model.
module tb_uart_transmitter_fifo;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  data_in;
    logic        valid8, valid5;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic [15:0] baud_div;
    logic        rdy8, so8, busy8, rdy5, so5, busy5;
    logic [2:0]  cnt8, cnt5;

    int checks = 0;
    int errors = 0;
    int stalls;
    logic       exp_q[$];
    logic [7:0] word_q[$];
    event       pushed_first;

    uart_transmitter_fifo #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .FIFO_DEPTH(4)) dut8 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(valid8), .data_in_ready(rdy8),
        .parity_mode(parity_mode), .two_stop(two_stop), .baud_div(baud_div),
        .serial_out(so8), .busy(busy8), .fifo_count(cnt8));

    uart_transmitter_fifo #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(5), .FIFO_DEPTH(4)) dut5 (
        .clk(clk), .rst(rst), .data_in(data_in[4:0]), .data_in_valid(valid5), .data_in_ready(rdy5),
        .parity_mode(parity_mode), .two_stop(two_stop), .baud_div(baud_div),
        .serial_out(so5), .busy(busy5), .fifo_count(cnt5));

    function automatic int eff_div(input logic [15:0] d);
        if (d == 16'd0) return 10;
        if (d == 16'd1) return 2;
        return int'(d);
    endfunction

    // Model: one frame as a list of line levels, each held for dv clocks
    task automatic add_frame(input logic [7:0] w, input int nb, input logic [1:0] m, input logic ts, input int dv);
        logic bits[$];
        int   ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(w[i]);
            if (w[i]) ones++;
        end
        if (m == 2'b01) bits.push_back((ones % 2) == 1);
        else if (m == 2'b10) bits.push_back((ones % 2) == 0);
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        foreach (bits[b]) repeat (dv) exp_q.push_back(bits[b]);
    endtask

    task automatic push_all(input bit sel5);
        bit acc;
        bit first;
        int budget;
        first = 1'b1;
        foreach (word_q[i]) begin
            data_in = word_q[i];
            if (sel5) valid5 = 1'b1; else valid8 = 1'b1;
            budget = 0;
            do begin
                acc = sel5 ? rdy5 : rdy8;
                if (!acc) begin
                    stalls++;
                    checks++;
                    if ((sel5 ? cnt5 : cnt8) !== 3'd4) begin
                        errors++;
                        $display("FAIL ready_low_count: fifo_count=%0d while not ready, expected 4", sel5 ? cnt5 : cnt8);
                    end
                end
                @(posedge clk); #1;
                budget++;
            end while (!acc && budget < 2000);
            if (!acc) begin
                errors++;
                $display("FAIL push_timeout: ready never rose, word %0d not accepted", i);
            end
            if (first) begin
                first = 1'b0;
                ->pushed_first;
            end
        end
        valid8 = 1'b0;
        valid5 = 1'b0;
    endtask

    task automatic check_wave(input bit sel5, input string name);
        @(pushed_first);
        @(posedge clk);
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if ((sel5 ? so5 : so8) !== exp_q[i]) begin
                errors++;
                $display("FAIL %s line cycle %0d: serial_out=%b expected %b", name, i, sel5 ? so5 : so8, exp_q[i]);
            end
            checks++;
            if ((sel5 ? busy5 : busy8) !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: busy=%b expected 1", name, i, sel5 ? busy5 : busy8);
            end
        end
        @(negedge clk);
        checks++;
        if ((sel5 ? so5 : so8) !== 1'b1 || (sel5 ? busy5 : busy8) !== 1'b0 || (sel5 ? cnt5 : cnt8) !== 3'd0) begin
            errors++;
            $display("FAIL %s idle_after: line=%b busy=%b count=%0d expected 1,0,0", name,
                     sel5 ? so5 : so8, sel5 ? busy5 : busy8, sel5 ? cnt5 : cnt8);
        end
    endtask

    task automatic run_stream(input bit sel5, input bit scramble, input string name);
        fork
            push_all(sel5);
            check_wave(sel5, name);
            if (scramble) begin
                @(pushed_first);
                @(posedge clk); #2;
                parity_mode = 2'($urandom);
                two_stop    = 1'($urandom);
                baud_div    = 16'($urandom_range(0, 6));
            end
        join
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic ts, input logic [15:0] d);
        parity_mode = m;
        two_stop    = ts;
        baud_div    = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (so8 !== 1'b1 || busy8 !== 1'b0 || cnt8 !== 3'd0 || rdy8 !== 1'b1 || so5 !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: line=%b busy=%b count=%0d ready=%b line5=%b expected 1,0,0,1,1",
                     so8, busy8, cnt8, rdy8, so5);
        end
    endtask

    task automatic test_basic();
        set_cfg(2'b00, 1'b0, 16'd4);
        word_q = '{8'h55};
        exp_q  = {};
        add_frame(8'h55, 8, 2'b00, 1'b0, 4);
        run_stream(1'b0, 1'b0, "basic_55");
    endtask

    task automatic test_parity();
        set_cfg(2'b01, 1'b0, 16'd4);
        word_q = '{8'h07};
        exp_q  = {};
        add_frame(8'h07, 8, 2'b01, 1'b0, 4);
        run_stream(1'b0, 1'b0, "parity_even");
        set_cfg(2'b10, 1'b0, 16'd4);
        exp_q = {};
        add_frame(8'h07, 8, 2'b10, 1'b0, 4);
        run_stream(1'b0, 1'b0, "parity_odd");
    endtask

    task automatic test_back_to_back();
        set_cfg(2'b00, 1'b1, 16'd4);
        word_q = '{8'hA3, 8'h3C};
        exp_q  = {};
        add_frame(8'hA3, 8, 2'b00, 1'b1, 4);
        add_frame(8'h3C, 8, 2'b00, 1'b1, 4);
        run_stream(1'b0, 1'b0, "back_to_back");
    endtask

    task automatic test_fifo_full();
        logic [1:0] m;
        logic       ts;
        m  = 2'($urandom);
        ts = 1'($urandom);
        set_cfg(m, ts, 16'd16);
        word_q = {};
        exp_q  = {};
        for (int i = 0; i < 6; i++) begin
            word_q.push_back(8'($urandom));
            add_frame(word_q[i], 8, m, ts, 16);
        end
        stalls = 0;
        run_stream(1'b0, 1'b0, "fifo_full");
        checks++;
        if (stalls == 0) begin
            errors++;
            $display("FAIL fifo_full_stall: ready never dropped (stalls=%0d), expected >0", stalls);
        end
    endtask

    task automatic test_random();
        logic [7:0]  w;
        logic [1:0]  m;
        logic        ts;
        logic [15:0] bd;
        for (int k = 0; k < 8; k++) begin
            w  = 8'($urandom);
            m  = 2'($urandom);
            ts = 1'($urandom);
            bd = 16'($urandom_range(0, 6));
            set_cfg(m, ts, bd);
            word_q = '{w};
            exp_q  = {};
            add_frame(w, 8, m, ts, eff_div(bd));
            run_stream(1'b0, 1'b1, "random");
        end
    endtask

    task automatic test_reset_midframe();
        bit stayed;
        set_cfg(2'b00, 1'b0, 16'd4);
        word_q = '{8'h00, 8'hFF, 8'h81};
        fork
            push_all(1'b0);
            begin
                @(pushed_first);
                @(posedge clk);
                repeat (14) @(negedge clk);
                checks++;
                if (so8 !== 1'b0 || cnt8 !== 3'd2) begin
                    errors++;
                    $display("FAIL midframe_pre: line=%b count=%0d expected 0,2", so8, cnt8);
                end
                @(posedge clk); #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                checks++;
                if (so8 !== 1'b1 || cnt8 !== 3'd0 || busy8 !== 1'b0) begin
                    errors++;
                    $display("FAIL midframe_reset: line=%b count=%0d busy=%b expected 1,0,0", so8, cnt8, busy8);
                end
            end
        join
        stayed = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (so8 !== 1'b1 || busy8 !== 1'b0) stayed = 1'b0;
        end
        checks++;
        if (!stayed) begin
            errors++;
            $display("FAIL midframe_quiet: a frame appeared after reset, got stayed=%b expected 1", stayed);
        end
    endtask

    task automatic test_default_div();
        set_cfg(2'b00, 1'b0, 16'd0);
        word_q = '{8'h1F};
        exp_q  = {};
        add_frame(8'h1F, 5, 2'b00, 1'b0, 10);
        run_stream(1'b1, 1'b0, "default_div5");
        exp_q = {};
        add_frame(8'h1F, 8, 2'b00, 1'b0, 10);
        run_stream(1'b0, 1'b0, "default_div8");
        set_cfg(2'b00, 1'b0, 16'd1);
        exp_q = {};
        add_frame(8'h1F, 8, 2'b00, 1'b0, 2);
        run_stream(1'b0, 1'b0, "div_one");
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        data_in = 8'h00;
        valid8  = 1'b0;
        valid5  = 1'b0;
        set_cfg(2'b00, 1'b0, 16'd4);
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_fifo_full();
        test_random();
        test_reset_midframe();
        test_default_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
